// File: rtl/haz_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, operand-forward
// selects and the per-stage shadow scoreboard record.
package haz_pkg;

  localparam int HAZ_REG_AW = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } haz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [HAZ_REG_AW-1:0] rd;
    logic                  we;
    logic                  load;
  } stage_rec_t;

  localparam stage_rec_t STAGE_EMPTY = '{valid: 1'b0, rd: '0, we: 1'b0, load: 1'b0};

  // True when the stage will write a non-zero register equal to src.
  function automatic logic rec_writes(input stage_rec_t rec,
                                      input logic [HAZ_REG_AW-1:0] src);
    return rec.valid & rec.we & (src != '0) & (rec.rd == src);
  endfunction

endpackage

// File: rtl/haz_fwd_unit.sv
// Per-operand forwarding and load-use detector; purely combinational, one copy
// per source register of the instruction in ID.
module haz_fwd_unit
  import haz_pkg::*;
(
  input  logic [HAZ_REG_AW-1:0] i_rs,
  input  logic                  i_use,
  input  stage_rec_t            i_ex,
  input  stage_rec_t            i_mem,
  output logic [1:0]            o_sel,
  output logic                  o_lu_hit
);

  logic w_ex_match;
  logic w_mem_match;

  assign w_ex_match  = i_use & rec_writes(i_ex, i_rs);
  assign w_mem_match = i_use & rec_writes(i_mem, i_rs);

  // A matching load in EX has no result yet; the stall covers it, so only
  // non-load EX producers are forwarded and the select falls through to MEM.
  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_match && !i_ex.load) begin
      o_sel = FWD_EX;
    end else if (w_mem_match) begin
      o_sel = FWD_MEM;
    end
  end

  assign o_lu_hit = w_ex_match & i_ex.load;

endmodule

// File: rtl/haz_pipe_ctrl.sv
// Hazard/sequencing controller for the 4-stage pipeline: shadow EX/MEM
// scoreboard, forwarding, load-use stall, flush and memory-wait freeze.
// Optional stall statistics counter enabled with `define HAZ_STATS_EN.
//
// Handshake: mem_ready is sampled only while a load sits in MEM; the stage
// registers hold whenever freeze=1 and resume on the cycle mem_ready=1.
module haz_pipe_ctrl
  import haz_pkg::*;
#(
  parameter int REG_AW = HAZ_REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt
);

  haz_state_t r_state;
  stage_rec_t r_ex;
  stage_rec_t r_mem;

  logic       w_lu_a;
  logic       w_lu_b;
  logic       w_load_use;
  logic       w_freeze;
  logic       w_bubble;
  logic       w_stall;
  stage_rec_t w_id_rec;

  haz_fwd_unit u_fwd_a (
    .i_rs     (id_rs1),
    .i_use    (id_valid & id_use_rs1),
    .i_ex     (r_ex),
    .i_mem    (r_mem),
    .o_sel    (fwd_a),
    .o_lu_hit (w_lu_a)
  );

  haz_fwd_unit u_fwd_b (
    .i_rs     (id_rs2),
    .i_use    (id_valid & id_use_rs2),
    .i_ex     (r_ex),
    .i_mem    (r_mem),
    .o_sel    (fwd_b),
    .o_lu_hit (w_lu_b)
  );

  // Priority freeze > flush > load-use: a flushed ID instruction is discarded,
  // so any load-use it would have raised is moot.
  assign w_load_use = w_lu_a | w_lu_b;
  assign w_freeze   = r_mem.valid & r_mem.load & ~mem_ready;
  assign w_bubble   = ~w_freeze & ~flush & w_load_use;
  assign w_stall    = w_freeze | w_bubble;

  assign w_id_rec = '{valid: id_valid, rd: id_rd, we: id_we, load: id_is_load};

  assign stall_if  = w_stall;
  assign stall_id  = w_stall;
  assign bubble_ex = w_bubble;
  assign freeze    = w_freeze;
  assign state_o   = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_ex    <= STAGE_EMPTY;
      r_mem   <= STAGE_EMPTY;
    end else begin
      if (!w_freeze) begin
        r_mem <= r_ex;
        r_ex  <= (w_bubble || flush) ? STAGE_EMPTY : w_id_rec;
      end
      // Same transition rules from every state; LU_STALL and MEM_WAIT differ
      // only in what the scoreboard looks like when they are entered.
      case (r_state)
        ST_RUN, ST_LU_STALL, ST_MEM_WAIT: begin
          if (w_freeze) begin
            r_state <= ST_MEM_WAIT;
          end else if (w_bubble) begin
            r_state <= ST_LU_STALL;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_haz_pipe_ctrl.sv
// Self-checking bench for haz_pipe_ctrl: directed scenarios plus a randomized
// run against an instruction-level reference model.
module tb_haz_pipe_ctrl;

  localparam int REG_AW = 3;
  localparam int CNT_W  = 16;
`ifdef HAZ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_use_rs1, id_use_rs2, id_we, id_is_load;
  logic              flush, mem_ready;
  logic              stall_if, stall_id, bubble_ex, freeze;
  logic [1:0]        fwd_a, fwd_b, state_o;
  logic [CNT_W-1:0]  stall_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  haz_pipe_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .flush(flush), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .freeze(freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state_o(state_o), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instructions currently occupying EX and MEM.
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } slot_t;

  slot_t  m_ex, m_mem;
  int     m_state;
  longint m_cnt;

  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1,
                       input bit u2, input int rd, input bit we, input bit ld,
                       input bit fl, input bit mr);
    id_valid   = v;
    id_rs1     = rs1[REG_AW-1:0];
    id_rs2     = rs2[REG_AW-1:0];
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    id_rd      = rd[REG_AW-1:0];
    id_we      = we;
    id_is_load = ld;
    flush      = fl;
    mem_ready  = mr;
  endtask

  task automatic model_reset();
    m_ex    = '{v: 0, rd: 0, we: 0, ld: 0};
    m_mem   = '{v: 0, rd: 0, we: 0, ld: 0};
    m_state = 0;
    m_cnt   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic bit reads(int src, bit use_bit, slot_t s);
    return id_valid && use_bit && src != 0 && s.v && s.we && s.rd == src;
  endfunction

  function automatic logic [1:0] pick(int src, bit use_bit);
    if (reads(src, use_bit, m_ex) && !m_ex.ld) return 2'b01;
    if (reads(src, use_bit, m_mem)) return 2'b10;
    return 2'b00;
  endfunction

  // Expected controls for the current inputs: {stall, bubble, freeze}.
  function automatic logic [2:0] predict();
    bit waiting, lu;
    waiting = m_mem.v && m_mem.ld && !mem_ready;
    lu = m_ex.ld && (reads(int'(id_rs1), id_use_rs1, m_ex) ||
                     reads(int'(id_rs2), id_use_rs2, m_ex));
    return {waiting || (!flush && lu), !waiting && !flush && lu, waiting};
  endfunction

  task automatic model_clock();
    logic [2:0] p;
    p = predict();
    if (!p[0]) begin
      m_mem = m_ex;
      if (flush || p[1] || !id_valid) m_ex = '{v: 0, rd: 0, we: 0, ld: 0};
      else m_ex = '{v: 1, rd: int'(id_rd), we: id_we, ld: id_is_load};
    end
    m_state = p[0] ? 2 : (p[1] ? 1 : 0);
    if (STATS && p[2] && m_cnt < (64'd1 << CNT_W) - 1) m_cnt++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 2, 1, 1, 3, 1, 1, 0, 0);
    #1;
    tests_run++;
    if ({stall_if, stall_id, bubble_ex, freeze, fwd_a, fwd_b, state_o, stall_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got ctl=%b%b%b%b fa=%b fb=%b st=%b cnt=%0d required all 0",
               stall_if, stall_id, bubble_ex, freeze, fwd_a, fwd_b, state_o, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forward_ex_mem();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);            // ADD r1
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 5, 0, 0, 0, 1);            // reads r1, r1 in EX
    #1;
    tests_run++;
    if (fwd_a !== 2'b01 || stall_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_ex got fwd_a=%b stall=%b required 01/0", fwd_a, stall_id);
    end
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 1);            // r1 now in MEM only
    #1;
    tests_run++;
    if (fwd_a !== 2'b10 || stall_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_mem got fwd_a=%b stall=%b required 10/0", fwd_a, stall_id);
    end
  endtask

  task automatic test_forward_priority();
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 1);
    @(negedge clk);
    drive(1, 0, 2, 0, 1, 0, 0, 0, 0, 1);
    #1;
    tests_run++;
    if (fwd_b !== 2'b01) begin
      tests_failed++;
      $display("FAIL fwd_ex_priority got fwd_b=%b required 01", fwd_b);
    end
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    #1;
    tests_run++;
    if (fwd_b !== 2'b00 || fwd_a !== 2'b00) begin
      tests_failed++;
      $display("FAIL fwd_r0 got fwd_a=%b fwd_b=%b required 00/00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 1);            // LOAD r3
    @(negedge clk);
    drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 1);
    #1;
    tests_run++;
    if ({stall_if, stall_id, bubble_ex, freeze} !== 4'b1110 || state_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL lu_stall got ctl=%b%b%b%b st=%b required 1110/00",
               stall_if, stall_id, bubble_ex, freeze, state_o);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({stall_if, stall_id, bubble_ex, freeze} !== 4'b0000 || state_o !== 2'b01 ||
        fwd_a !== 2'b10) begin
      tests_failed++;
      $display("FAIL lu_release got ctl=%b%b%b%b st=%b fa=%b required 0000/01/10",
               stall_if, stall_id, bubble_ex, freeze, state_o, fwd_a);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    tests_run++;
    if (state_o !== 2'b00 || stall_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL lu_back_to_run got st=%b stall=%b required 00/0", state_o, stall_id);
    end
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_st;
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 1);            // LOAD r4
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      exp_st = (i == 0) ? 2'b00 : 2'b10;
      tests_run++;
      if ({stall_if, stall_id, bubble_ex, freeze} !== 4'b1101 || state_o !== exp_st) begin
        tests_failed++;
        $display("FAIL mem_wait_%0d got ctl=%b%b%b%b st=%b required 1101/%b",
                 i, stall_if, stall_id, bubble_ex, freeze, state_o, exp_st);
      end
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if (freeze !== 1'b0 || stall_id !== 1'b0 || state_o !== 2'b10) begin
      tests_failed++;
      $display("FAIL mem_ready_cycle got frz=%b stall=%b st=%b required 0/0/10",
               freeze, stall_id, state_o);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (freeze !== 1'b0 || state_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL mem_wait_exit got frz=%b st=%b required 0/00", freeze, state_o);
    end
  endtask

  task automatic test_flush_vs_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 1);            // LOAD r5
    @(negedge clk);
    drive(1, 5, 0, 1, 0, 6, 1, 0, 1, 1);            // uses r5, flushed
    #1;
    tests_run++;
    if ({stall_if, stall_id, bubble_ex, freeze} !== 4'b0000 || state_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL flush_lu got ctl=%b%b%b%b st=%b required 0000/00",
               stall_if, stall_id, bubble_ex, freeze, state_o);
    end
    @(negedge clk);
    drive(1, 5, 6, 1, 1, 0, 0, 0, 0, 1);
    #1;
    tests_run++;
    if (state_o !== 2'b00 || stall_id !== 1'b0 || fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
      tests_failed++;
      $display("FAIL flush_dropped got st=%b stall=%b fa=%b fb=%b required 00/0/10/00",
               state_o, stall_id, fwd_a, fwd_b);
    end
  endtask

  task automatic test_stats();
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) begin
      @(negedge clk);
      mem_ready = 1'b0;
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (freeze !== 1'b0 || state_o !== 2'b00 || stall_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_wait got frz=%b st=%b cnt=%0d required 0/00/0",
               freeze, state_o, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 1);            // LOAD r3
    @(negedge clk);
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 1);            // load-use stall
    repeat (3) begin
      @(negedge clk);
      mem_ready = 1'b0;                             // freeze cycles
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    exp_cnt = STATS ? CNT_W'(4) : '0;
    tests_run++;
    if (stall_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL stall_count got %0d required %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic [2:0] p;
    logic [9:0] exp_v, got_v;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      #1;
      p = predict();
      exp_v = {p[2], p[2], p[1], p[0], pick(int'(id_rs1), id_use_rs1),
               pick(int'(id_rs2), id_use_rs2), 2'(m_state)};
      got_v = {stall_if, stall_id, bubble_ex, freeze, fwd_a, fwd_b, state_o};
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL rand_ctrl cyc=%0d got %b required %b", n, got_v, exp_v);
      end
      tests_run++;
      if (stall_cnt !== CNT_W'(m_cnt)) begin
        tests_failed++;
        $display("FAIL rand_cnt cyc=%0d got %0d required %0d", n, stall_cnt, m_cnt);
      end
      model_clock();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    test_reset();
    test_forward_ex_mem();
    test_forward_priority();
    test_load_use();
    test_mem_wait();
    test_flush_vs_load_use();
    test_stats();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/haz_pipe_ctrl.md
Name: haz_pipe_ctrl

Overview:
Hazard and sequencing controller for the 4-stage (IF/ID/EX/MEM-WB) pipeline behind the fsm_haz top.
- Keeps a shadow scoreboard of the EX and MEM stages.
- Detects RAW hazards against the instruction in ID.
- Drives forwarding selects, load-use stalls with bubble insertion, branch flushes, and a full-pipe freeze while a load waits on memory.
- Sits between the decode stage and the datapath stage-enable and mux controls.

Parameters:
- REG_AW, 3, register-address width (8 architectural registers; r0 hardwired zero).
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  valid instruction in ID.
- id_rs1  in  REG_AW  source 1 address.
- id_rs2  in  REG_AW  source 2 address.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_AW  destination address.
- id_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  branch taken, resolved in EX.
- mem_ready  in  1  load data valid this cycle.
- stall_if  out  1  hold PC/IF register.
- stall_id  out  1  hold ID register.
- bubble_ex  out  1  load NOP into EX.
- freeze  out  1  hold every stage register.
- fwd_a  out  2  rs1 operand select: 00 regfile, 01 EX result, 10 MEM result.
- fwd_b  out  2  rs2 operand select, same encoding.
- state_o  out  2  FSM state, for debug.
- stall_cnt  out  CNT_W  stall statistics (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - shadow ex_/mem_ valid bits cleared; state=RUN.
  - all outputs 0; fwd_a = fwd_b = 00; stall_cnt=0.
  - Reset mid-operation discards in-flight scoreboard entries immediately.
- Shadow pipeline (ex_valid/rd/we/load, mem_valid/rd/we/load):
  - advances on each clk edge when freeze=0.
  - EX entry gets ID fields, or valid=0 if bubble_ex or flush.
- Hazard match: src==rd, src!=0, use bit set, stage valid and we set.
- Load-use hazard: match with EX and ex_load=1.
- Forwarding (combinational, for the ID instruction):
  - EX match with non-load → 01.
  - else MEM match → 10.
  - else 00.
  - EX takes priority over MEM when both match.
- States: RUN=00, LU_STALL=01, MEM_WAIT=10. Priority within a cycle: freeze > flush > load-use.
- Freeze condition: mem_valid & mem_load & !mem_ready.
  - freeze=1, stall_if=1, stall_id=1, bubble_ex=0; scoreboard holds; next state MEM_WAIT.
  - flush is ignored while freeze=1; the source must hold it.
- RUN, flush=1:
  - EX entry invalid; ID is not inserted; no stall even if load-use; next RUN.
- RUN, load-use:
  - stall_if = stall_id = bubble_ex = 1 combinationally that cycle; next LU_STALL.
- LU_STALL:
  - load now in MEM; no new stall for the same pair (forwarding from MEM = 10).
  - next MEM_WAIT if the freeze condition holds, else RUN; a new load-use from a different pair re-enters LU_STALL.
- MEM_WAIT:
  - freeze held while mem_ready=0.
  - the cycle mem_ready=1: freeze=0, pipeline advances, next RUN.
  - no timeout.
- Single-cycle stall depth: back-to-back load-use sequences stall 1 cycle each.

Optional Feature:
- HAZ_STATS_EN defined: stall_cnt increments on every clk edge where stall_id=1 (load-use or freeze); saturates at all-ones; cleared only by rst.
- Undefined: no counter logic; stall_cnt tied to 0.

Decomposition:
- Shared package haz_pkg:
  - state encoding (RUN/LU_STALL/MEM_WAIT).
  - fwd encoding constants (FWD_RF=00, FWD_EX=01, FWD_MEM=10).
  - stage scoreboard record type (valid, rd, we, load).
- Sub-module haz_fwd_unit: purely combinational.
  - Inputs: rs, use bit, EX and MEM records.
  - Outputs: 2-bit select and load-use hit.
  - Instantiated twice (rs1, rs2).

Test Plan:
- ADD r1 in EX, ID reads rs1=r1 → fwd_a=01, no stall. Repeat with r1 in MEM only → fwd_a=10.
- Same rd=r2 in both EX and MEM, ID rs2=r2 → fwd_b=01 (EX priority). With rs=r0 → 00.
- LOAD r3 in EX, ID rs1=r3 → stall_if/stall_id/bubble_ex=1 for exactly 1 cycle; state 00→01→00; next cycle fwd_a=10.
- LOAD in MEM, mem_ready=0 for 3 cycles → freeze=1 for 3 cycles, state=10; mem_ready=1 → freeze=0 that cycle, then RUN.
- Load-use and flush in the same cycle → no stall, EX bubble, state stays RUN.
- HAZ_STATS_EN build: assert rst mid MEM_WAIT → freeze=0, state=00, stall_cnt=0 immediately. Then 1 load-use + 3 MEM_WAIT cycles → stall_cnt=4.
